// File: rtl/rr_mux_arb_nw_pkg.sv
// Shared types and the round-robin search function for rr_mux_arb_nw.
// Optional build macro: RR_MUX_FIXED_PRI_EN (fixed lowest-index priority).
package mux_arb_pkg;

  localparam int N_MAX = 16;

  typedef logic [3:0] chan_idx_t;

  // First requester after ptr, wrapping at n (n need not be a power of two).
  function automatic chan_idx_t rr_pick(input logic [N_MAX-1:0] req,
                                        input chan_idx_t         ptr,
                                        input int                n);
    logic [4:0] s;
    chan_idx_t  idx;
    chan_idx_t  result;
    logic       found;
    result = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_MAX; k++) begin
      s = {1'b0, ptr} + 5'(k);
      if (s >= 5'(n)) s = s - 5'(n);
      idx = s[3:0];
      if (k <= n && !found && req[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_mux_arb_nw_if.sv
// Channel-side and sink-side handshake bundle of rr_mux_arb_nw.
interface rr_mux_arb_nw_if #(
  parameter int N = 8,
  parameter int W = 16
);
  // Handshake: a word moves when valid and ready are both 1 at a rising edge.
  // in_ready is a one-hot grant (or zero) and never depends on in_ready itself;
  // out_valid stays high with stable out_data/out_sel until out_ready is seen.
  logic [N-1:0]         in_valid;
  logic [N*W-1:0]       in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic [$clog2(N)-1:0] out_sel;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arb_nw_pick.sv
// Combinational picker: grant index of the first request after ptr.
module rr_pick_nw
  import mux_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  chan_idx_t    ptr,
  output chan_idx_t    gnt_idx,
  output logic         gnt_any
);

  assign gnt_idx = rr_pick(N_MAX'(req), ptr, N);
  assign gnt_any = |req;

endmodule

// File: rtl/rr_mux_arb_nw.sv
// N-channel W-bit round-robin arbitrated mux with one registered output stage.
// Define RR_MUX_FIXED_PRI_EN for fixed lowest-index-first priority.
module rr_mux_arb_nw
  import mux_arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  rr_mux_arb_nw_if.slave bus
);

  localparam int SW = $clog2(N);

  chan_idx_t    ptr;
  chan_idx_t    gnt_idx;
  logic         gnt_any;
  logic         load;
  logic [W-1:0] sel_data;
  logic [N-1:0] ready;

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [SW-1:0] out_sel_q;

  rr_pick_nw #(.N(N)) u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Register is free when empty or being drained on this same edge.
  assign load = ~out_valid_q | bus.out_ready;

  always_comb begin
    sel_data = '0;
    ready    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == chan_idx_t'(i)) begin
        sel_data = bus.in_data[i*W +: W];
        ready[i] = load & ~Reset & gnt_any;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef RR_MUX_FIXED_PRI_EN
  // A pointer pinned at N-1 makes the search start at channel 0 every time.
  assign ptr = chan_idx_t'(N-1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sel_q   <= gnt_idx[SW-1:0];
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr         <= chan_idx_t'(N-1);
    end else if (load) begin
      if (gnt_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_sel_q   <= gnt_idx[SW-1:0];
        ptr         <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux_arb_nw.sv
// Directed and random checks of rr_mux_arb_nw with a grant-order scoreboard.
module tb_rr_mux_arb_nw;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = $clog2(N);
  localparam int EW = SW + W;

  logic Clk;
  logic Reset;

  rr_mux_arb_nw_if #(.N(N), .W(W)) bus ();

  rr_mux_arb_nw #(.N(N), .W(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  int            m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_ramp_data();
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = 16'h1000 + 16'(i);
  endtask

  // Scoreboard: predicts each grant at the negedge before the edge that takes it
  always @(negedge Clk) begin : mon
    logic          mv;
    logic [N-1:0]  exp_rdy;
    logic [EW-1:0] e;
    int            g;
    mv = (exp_q.size() != 0);
    chk("mon_out_valid", 32'(bus.out_valid), 32'(mv));
    if (Reset) begin
      exp_q.delete();
      m_ptr = N - 1;
      chk("mon_rst_in_ready", 32'(bus.in_ready), 32'h0);
    end else begin
      if (mv && bus.out_ready) begin
        e = exp_q.pop_front();
        chk("mon_out_sel",  32'(bus.out_sel),  32'(e[EW-1:W]));
        chk("mon_out_data", 32'(bus.out_data), 32'(e[W-1:0]));
      end
      exp_rdy = '0;
      if (!mv || bus.out_ready) begin
        g = -1;
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && bus.in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g >= 0) begin
          exp_rdy[g] = 1'b1;
          exp_q.push_back({SW'(g), bus.in_data[g*W +: W]});
`ifndef RR_MUX_FIXED_PRI_EN
          m_ptr = g;
`endif
        end
      end
      chk("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    end
  end

  initial begin
    m_ptr         = N - 1;
    Reset         = 1'b1;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    set_ramp_data();

    // Reset held for two edges with every channel requesting
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_sel",   32'(bus.out_sel),   32'h0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
    Reset = 1'b0;
    #1;
    chk("rel_in_ready_ch0", 32'(bus.in_ready), 32'h01);

`ifndef RR_MUX_FIXED_PRI_EN
    // Full round-robin sweep with sink always ready
    for (int k = 0; k <= N; k++) begin
      cyc();
      chk("rr_out_valid", 32'(bus.out_valid), 32'h1);
      chk("rr_out_sel",   32'(bus.out_sel),   32'(k % N));
      chk("rr_out_data",  32'(bus.out_data),  32'h1000 + 32'(k % N));
    end

    // Backpressure: word 0 held for three edges, then ch1 loads with no bubble
    bus.out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_out_data",  32'(bus.out_data),  32'h1000);
      chk("bp_out_sel",   32'(bus.out_sel),   32'h0);
      chk("bp_in_ready",  32'(bus.in_ready),  32'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'h02);
    cyc();
    chk("bp_next_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_next_sel",   32'(bus.out_sel),   32'h1);

    // Sparse requests and wrap after a ch7 grant
    bus.in_valid = 8'h80;
    cyc();
    chk("wrap_sel7", 32'(bus.out_sel), 32'h7);
    bus.in_valid = 8'b0010_0100;
    cyc();
    chk("sparse_sel_a", 32'(bus.out_sel), 32'h2);
    cyc();
    chk("sparse_sel_b", 32'(bus.out_sel), 32'h5);
    cyc();
    chk("sparse_sel_c", 32'(bus.out_sel), 32'h2);
    bus.in_valid = '0;
    cyc();
    chk("idle_out_valid", 32'(bus.out_valid), 32'h0);
    chk("idle_out_data",  32'(bus.out_data),  32'h1002);

    // Reset while a word is held under backpressure
    bus.in_valid  = 8'h30;
    bus.out_ready = 1'b0;
    cyc();
    chk("mid_load_sel", 32'(bus.out_sel), 32'h4);
    cyc();
    chk("mid_hold_valid", 32'(bus.out_valid), 32'h1);
    Reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'h0);
    cyc();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_out_data",  32'(bus.out_data),  32'h0);
    Reset         = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("mid_first_grant", 32'(bus.out_sel), 32'h4);
`else
    // Fixed priority: channel 0 always beats channel 7
    bus.in_valid = 8'b1000_0001;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("fixed_out_sel",   32'(bus.out_sel),   32'h0);
      chk("fixed_out_valid", 32'(bus.out_valid), 32'h1);
    end
`endif

    // Random traffic checked by the scoreboard
    for (int k = 0; k < 300; k++) begin
      bus.in_valid  = N'($urandom_range(0, (1 << N) - 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'($urandom_range(0, 65535));
      cyc();
    end

    // Drain and confirm nothing is left outstanding
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
